// File: rtl/mru_key_if.sv
// Command port of the MRU key player: one command code per valid/ready transfer.
//   cmd_valid  initiator -> player  command present on cmd_key
//   cmd_key    initiator -> player  0..4 = b1..b5, 5 = all five, 6..7 = illegal
//   cmd_ready  player -> initiator  command buffer can accept
interface mru_key_if;
  logic       cmd_valid;
  logic [2:0] cmd_key;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_key, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, output cmd_ready);
endinterface

// File: rtl/mru_key_player.sv
// Turns queued key commands into timed presses on b1..b5.
// Each press is held HOLD_CYCLES cycles, followed by GAP_CYCLES cycles with
// every key released. Commands are buffered in a FIFO_DEPTH-entry FIFO.
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   cmd        command port (slave side of mru_key_if)
//   b1..b5     key outputs, one-hot (or all high for code 5)
//   busy       pressing, in the gap, or commands still queued
//   cmd_err    one-cycle pulse after an illegal code is consumed
//   press_cnt  completed presses, wraps at 255
module mru_key_player #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  mru_key_if.slave   cmd,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       b4,
  output logic       b5,
  output logic       busy,
  output logic       cmd_err,
  output logic [7:0] press_cnt
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned MAX_CYC   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [4:0]         keys_q, keys_d;
  logic [7:0]         press_cnt_q, press_cnt_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [2:0]         mem [FIFO_DEPTH];

  logic               push;
  logic               legal;
  logic               wr_en;
  logic               pop;
  logic               not_empty;
  logic [2:0]         head;

  // Code 5 presses every key; 0..4 select b1..b5 (b1 is the MSB of keys).
  function automatic logic [4:0] decode(input logic [2:0] code);
    if (code == 3'd5) return 5'b11111;
    return 5'b10000 >> code;
  endfunction

  assign push      = cmd.cmd_valid & ready_q;
  assign legal     = (cmd.cmd_key <= 3'd5);
  assign wr_en     = push & legal;
  assign not_empty = (count_q != '0);
  assign head      = mem[rd_ptr_q];

  // Press sequencer: next state, timer, key image and press counter.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    keys_d      = keys_q;
    press_cnt_d = press_cnt_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          keys_d  = decode(head);
          timer_d = TMR_W'(HOLD_LOAD);
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (timer_q == '0) begin
          keys_d      = 5'b00000;
          press_cnt_d = press_cnt_q + 8'd1;
          if (GAP_CYCLES != 0) begin
            timer_d = TMR_W'(GAP_LOAD);
            state_d = GAP;
          end else if (not_empty) begin
            // No gap configured: the next press follows without a released cycle.
            pop     = 1'b1;
            keys_d  = decode(head);
            timer_d = TMR_W'(HOLD_LOAD);
            state_d = PRESS;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          if (not_empty) begin
            pop     = 1'b1;
            keys_d  = decode(head);
            timer_d = TMR_W'(HOLD_LOAD);
            state_d = PRESS;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        keys_d  = 5'b00000;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO occupancy and the registered status flags derived from it.
  always_comb begin
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    busy_d  = (state_d != IDLE) || (count_d != '0);
    err_d   = push & ~legal;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      keys_q      <= 5'b00000;
      press_cnt_q <= 8'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      keys_q      <= keys_d;
      press_cnt_q <= press_cnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      count_q     <= count_d;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: only entries written since reset are ever read.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_ptr_q] <= cmd.cmd_key;
  end

  assign cmd.cmd_ready = ready_q;
  assign b1        = keys_q[4];
  assign b2        = keys_q[3];
  assign b3        = keys_q[2];
  assign b4        = keys_q[1];
  assign b5        = keys_q[0];
  assign busy      = busy_q;
  assign cmd_err   = err_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_mru_key_player.sv
// Drives two players (GAP_CYCLES=2 and GAP_CYCLES=0) with the same command
// stream and compares every output, every cycle, against a timestamp model:
// each queued command starts at max(accept edge + 1, previous start + HOLD + GAP).
module tb_mru_key_player;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mru_key_if if_a ();
  mru_key_if if_b ();

  logic [4:0] a_b, b_b;
  logic       a_busy, b_busy, a_err, b_err;
  logic [7:0] a_cnt, b_cnt;

  mru_key_player #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(2), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst_n), .cmd(if_a.slave),
    .b1(a_b[4]), .b2(a_b[3]), .b3(a_b[2]), .b4(a_b[1]), .b5(a_b[0]),
    .busy(a_busy), .cmd_err(a_err), .press_cnt(a_cnt)
  );

  mru_key_player #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst_n), .cmd(if_b.slave),
    .b1(b_b[4]), .b2(b_b[3]), .b3(b_b[2]), .b4(b_b[1]), .b5(b_b[0]),
    .busy(b_busy), .cmd_err(b_err), .press_cnt(b_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state, one slot per instance.
  int gap_of [2] = '{2, 0};
  int pend_code [2][16];
  int pend_n [2];
  int have [2];
  int cur_start [2];
  int cur_code [2];
  int next_allowed [2];
  int done_cnt [2];
  bit m_rdy [2];
  bit m_err [2];
  int cyc = 0;

  function automatic logic [4:0] key_pattern(input int code);
    logic [4:0] p;
    p = 5'b00000;
    if (code == 5) p = 5'b11111;
    else p[4 - code] = 1'b1;
    return p;
  endfunction

  task automatic model_edge(input int i, input bit v, input int k, input bit r);
    bit acc;
    if (!r) begin
      pend_n[i] = 0; have[i] = 0; next_allowed[i] = 0;
      done_cnt[i] = 0; m_rdy[i] = 0; m_err[i] = 0;
      return;
    end
    acc = v && m_rdy[i];
    if (have[i] != 0 && cyc == cur_start[i] + HOLD) done_cnt[i] = (done_cnt[i] + 1) % 256;
    if (pend_n[i] > 0 && cyc >= next_allowed[i]) begin
      cur_code[i] = pend_code[i][0];
      for (int j = 1; j < pend_n[i]; j++) pend_code[i][j-1] = pend_code[i][j];
      pend_n[i]--;
      cur_start[i] = cyc;
      have[i] = 1;
      next_allowed[i] = cyc + HOLD + gap_of[i];
    end
    m_err[i] = acc && (k > 5);
    if (acc && k <= 5) begin
      pend_code[i][pend_n[i]] = k;
      pend_n[i]++;
    end
    m_rdy[i] = (pend_n[i] < DEPTH);
  endtask

  function automatic logic [4:0] exp_keys(input int i);
    if (have[i] != 0 && cyc >= cur_start[i] && cyc < cur_start[i] + HOLD)
      return key_pattern(cur_code[i]);
    return 5'b00000;
  endfunction

  function automatic bit exp_busy(input int i);
    return (have[i] != 0 && cyc < cur_start[i] + HOLD + gap_of[i]) || (pend_n[i] > 0);
  endfunction

  // One clock: drive, take the edge, advance the model, then compare.
  task automatic step(input bit v, input int k, input bit r);
    rst_n = r;
    if_a.cmd_valid = v; if_a.cmd_key = 3'(k);
    if_b.cmd_valid = v; if_b.cmd_key = 3'(k);
    @(posedge clk);
    cyc++;
    model_edge(0, v, k, r);
    model_edge(1, v, k, r);
    #1;
    check("a.keys",  32'(a_b),            32'(exp_keys(0)));
    check("a.busy",  32'(a_busy),         32'(exp_busy(0)));
    check("a.err",   32'(a_err),          32'(m_err[0]));
    check("a.cnt",   32'(a_cnt),          32'(done_cnt[0]));
    check("a.ready", 32'(if_a.cmd_ready), 32'(m_rdy[0]));
    check("b.keys",  32'(b_b),            32'(exp_keys(1)));
    check("b.busy",  32'(b_busy),         32'(exp_busy(1)));
    check("b.err",   32'(b_err),          32'(m_err[1]));
    check("b.cnt",   32'(b_cnt),          32'(done_cnt[1]));
    check("b.ready", 32'(if_b.cmd_ready), 32'(m_rdy[1]));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 0, 1'b1);
  endtask

  initial begin
    if_a.cmd_valid = 1'b0; if_a.cmd_key = 3'd0;
    if_b.cmd_valid = 1'b0; if_b.cmd_key = 3'd0;

    // Reset held three cycles, then released.
    for (int j = 0; j < 3; j++) step(1'b0, 0, 1'b0);
    idle(1);

    // Single press of b1.
    step(1'b1, 0, 1'b1);
    idle(10);

    // Burst of keys presented back-to-back (fills the FIFO).
    for (int k = 0; k < 5; k++) step(1'b1, k, 1'b1);
    idle(40);

    // Illegal code, then the all-keys code.
    step(1'b1, 6, 1'b1);
    idle(3);
    step(1'b1, 7, 1'b1);
    idle(3);
    step(1'b1, 5, 1'b1);
    idle(10);

    // Reset during the second cycle of the first press with commands queued.
    step(1'b1, 0, 1'b1);
    step(1'b1, 1, 1'b1);
    step(1'b1, 2, 1'b1);
    step(1'b0, 0, 1'b0);
    idle(12);

    // Keys 3 then 4, then a continuous stream long enough to wrap press_cnt.
    step(1'b1, 3, 1'b1);
    step(1'b1, 4, 1'b1);
    for (int j = 0; j < 1100; j++) step(1'b1, $urandom_range(0, 5), 1'b1);
    idle(20);

    // Random traffic with occasional resets.
    for (int j = 0; j < 1500; j++) begin
      bit r;
      r = ($urandom_range(0, 199) != 0);
      step(($urandom_range(0, 2) != 0), $urandom_range(0, 7), r);
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
